// File: rtl/if_fetch.sv
// if_fetch -- instruction fetch stage.
// Issues word reads to instruction memory from a fetch PC, buffers the
// returned words with their PCs in a 2-entry FIFO and presents the head to
// ID with a valid/ready handshake. A redirect from EX flushes everything
// that was fetched on the old path and restarts fetching at the target.
// Optional build macro: IF_MISALIGN_EN -- adds the if_exc port and the
// S_EXC state that traps redirects to non word-aligned targets.
module if_fetch #(
   parameter int              PC_W     = 10,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            inst_ce,
   output logic [PC_W-1:0] inst_addr,
   input  logic [31:0]     inst_rdata,
   input  logic            redir_valid,
   input  logic [PC_W-1:0] redir_pc,
   output logic            if_valid,
   input  logic            id_ready,
   output logic [PC_W-1:0] if_pc,
   output logic [31:0]     if_inst
`ifdef IF_MISALIGN_EN
   ,
   output logic            if_exc
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
`ifdef IF_MISALIGN_EN
   localparam logic [1:0] S_EXC  = 2'd2;
`endif
   localparam int DEPTH = 2;

   logic [1:0]      state_reg;
   logic [PC_W-1:0] fpc_reg;
   logic            inflight_reg;
   logic [PC_W-1:0] inflight_pc_reg;
   logic [PC_W-1:0] fifo_pc_mem   [DEPTH];
   logic [31:0]     fifo_inst_mem [DEPTH];
   logic            rd_ptr_reg;
   logic            wr_ptr_reg;
   logic [1:0]      count_reg;

   logic [PC_W-1:0] redir_target;
   logic            fifo_valid;
   logic            pop;
   logic            push;
   logic            credit;
   logic            issue;

`ifdef IF_MISALIGN_EN
   assign redir_target = redir_pc;
`else
   // Without the trap, the low address bits of a redirect are simply ignored.
   logic [1:0] unused_redir_lsbs;
   assign unused_redir_lsbs = redir_pc[1:0];
   assign redir_target      = {redir_pc[PC_W-1:2], 2'b00};
`endif

   // Handshake and flow control. A new request may only go out if the FIFO
   // is guaranteed a free slot when its response comes back next cycle.
   assign fifo_valid = (count_reg != 2'd0);
   assign if_valid   = !rst && fifo_valid;
   assign pop        = if_valid && id_ready;
   assign credit     = ({1'b0, count_reg} + {2'b00, inflight_reg}) < (3'd2 + {2'b00, pop});
   // No request during a redirect: it would be on the discarded path anyway.
   assign issue      = !rst && !redir_valid && (state_reg == S_RUN) && credit;
   // The response of the previous cycle's request is dropped on a redirect.
   assign push       = inflight_reg && !redir_valid;

   assign inst_ce    = issue;
   assign inst_addr  = rst ? RESET_PC : fpc_reg;
   // Empty FIFO shows zeros, which ID decodes as a no-op.
   assign if_pc      = if_valid ? fifo_pc_mem[rd_ptr_reg]   : '0;
   assign if_inst    = if_valid ? fifo_inst_mem[rd_ptr_reg] : 32'd0;

`ifdef IF_MISALIGN_EN
   assign if_exc     = !rst && (state_reg == S_EXC);
`endif

   // Control state: FSM, fetch PC, in-flight tracking and FIFO pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= S_IDLE;
         fpc_reg         <= RESET_PC;
         inflight_reg    <= 1'b0;
         inflight_pc_reg <= RESET_PC;
         rd_ptr_reg      <= 1'b0;
         wr_ptr_reg      <= 1'b0;
         count_reg       <= 2'd0;
      end else begin
         inflight_reg <= issue;
         if (issue) begin
            inflight_pc_reg <= fpc_reg;
         end
         if (redir_valid) begin
            // Redirect overrides everything: flush and restart at the target.
            fpc_reg    <= redir_target;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
`ifdef IF_MISALIGN_EN
            state_reg  <= (redir_pc[1:0] != 2'b00) ? S_EXC : S_RUN;
`else
            state_reg  <= S_RUN;
`endif
         end else begin
            case (state_reg)
               S_IDLE: state_reg <= S_RUN;
               S_RUN: begin
                  // Wraps silently at the top of the PC space.
                  if (issue) begin
                     fpc_reg <= fpc_reg + PC_W'(4);
                  end
               end
`ifdef IF_MISALIGN_EN
               S_EXC: state_reg <= S_EXC;
`endif
               default: state_reg <= S_IDLE;
            endcase
            if (push) begin
               wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
               rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
         end
      end
   end

   // FIFO storage: each slot captures the returning word with the PC it was
   // requested from. Contents need no reset; validity comes from count_reg.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         // Write slot gi when it is the current write target.
         always_ff @(posedge clk) begin
            if (!rst && push && (wr_ptr_reg == 1'(gi))) begin
               fifo_pc_mem[gi]   <= inflight_pc_reg;
               fifo_inst_mem[gi] <= inst_rdata;
            end
         end
      end
   endgenerate

endmodule
